vedic_prod_accum: RTL
=====================

VEDIC_PROD_ACCUM -- requirements
Module: vedic_prod_accum

Interface
REQ-001 Parameter ACC_W, default 12: accumulator and sum width in bits, legal range 9..16.
REQ-002 Parameter BATCH, default 16: products per batch, legal range 1..255.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1: reset, asynchronous and active-low.
REQ-005 ena  in  1: design enable; when low, all state holds.
REQ-006 prod_in  in  8: unsigned 8-bit product from the 4x4 multiplier stage (0..225).
REQ-007 prod_vld  in  1: prod_in valid; one product is accepted per cycle while high.
REQ-008 acc_clr  in  1: synchronous batch abort/clear.
REQ-009 sum_out  out  ACC_W: registered batch sum; holds its value between results.
REQ-010 sum_vld  out  1: one-cycle pulse marking a new sum_out.
REQ-011 ovf  out  1: overflow flag for the batch currently shown on sum_out.
REQ-012 busy  out  1: high while a batch is partially accumulated (state ACC).
REQ-013 cnt_out  out  8: count of products accepted in the current batch.

Function
REQ-014 FSM states are IDLE, ACC and DONE; all outputs are registered.
REQ-015 A product is accepted on a rising edge when ena=1, prod_vld=1 and acc_clr=0.
REQ-016 IDLE or DONE with accept: acc<=prod_in, cnt<=1, next ACC; if BATCH=1, go to the completion path (REQ-018) instead.
REQ-017 ACC with accept: acc<=acc+prod_in, cnt<=cnt+1; any carry out of ACC_W bits sets the internal ovf_acc flag.
REQ-018 Completion, on acceptance of the BATCH-th product: sum_out<=final sum, ovf<=ovf_acc, sum_vld<=1, acc<=0, cnt<=0, ovf_acc<=0, next DONE.
REQ-019 Completion latency: sum_vld is high in the cycle after the edge that accepted the last product, for exactly one cycle.
REQ-020 DONE with no accept: next IDLE, sum_vld<=0.
REQ-021 DONE with accept: the product becomes the first of the next batch with no bubble (cnt_out=1).
REQ-022 ACC with prod_vld=0: state, acc and cnt hold; bubbles between products are legal.
REQ-023 acc_clr=1 (with ena=1) has highest priority: next IDLE, acc, cnt and ovf_acc <=0, sum_vld<=0; sum_out and ovf hold; a product presented in the same cycle is dropped.
REQ-024 ena=0: FSM, acc, cnt, sum_out and ovf hold; sum_vld<=0, so the pulse is never stretched; prod_vld is ignored.
REQ-025 busy=1 exactly when state is ACC; cnt_out mirrors cnt.

Reset
REQ-026 rst_n=0 immediately forces state IDLE and acc, cnt, ovf_acc, sum_out, sum_vld, ovf, busy and cnt_out to 0, regardless of clk or ena.
REQ-027 Reset mid-batch discards the partial batch; the first accept after release starts a new batch at cnt=1.

Configuration
REQ-028 Macro VEDIC_ACC_SATURATE_EN is defined: on overflow the accumulator clamps to 2^ACC_W-1 and remains clamped for the rest of the batch; ovf_acc is set.
REQ-029 Macro VEDIC_ACC_SATURATE_EN is undefined: the accumulator wraps modulo 2^ACC_W; ovf_acc is set on any wrap.

Verification
REQ-030 Defaults; products 6,20,225,0 then 12 more zeros, back-to-back -> one cycle after the 16th accept: sum_vld=1 for 1 cycle, sum_out=251, ovf=0, busy=0.
REQ-031 BATCH=4; products 3,4,5,6 with 2-cycle bubbles between them, plus one ena=0 cycle -> sum_out=18 exactly once; cnt_out steps 1,2,3 and holds during bubbles and the ena=0 cycle.
REQ-032 BATCH=4; 4x225 followed in the DONE cycle by prod_in=9 -> sum_out=900, sum_vld pulse; next cycle busy=1, cnt_out=1.
REQ-033 BATCH=4; two accepts (10,20), then acc_clr with prod_vld=1, prod_in=50 -> no sum_vld, cnt_out=0, sum_out unchanged; then 1,1,1,1 -> sum_out=4.
REQ-034 ACC_W=10, BATCH=8; 8x225 -> without the macro: sum_out=776, ovf=1; with the macro: sum_out=1023, ovf=1; the next clean batch clears ovf to 0.
REQ-035 Assert rst_n low in ACC after 3 accepts, between clock edges -> all outputs read 0 before the next edge; after release, a fresh batch of 16x1 gives sum_out=16.

Source files
------------

// File: rtl/vedic_prod_accum_if.sv
// Bus between the 4x4 Vedic multiplier stage and the batch product accumulator.
// Handshake: a product is taken on any rising clk edge where ena && prod_vld && !acc_clr
// (there is no ready; the accumulator never stalls), and sum_vld is a one-cycle pulse
// per completed batch with no back-pressure, so the consumer must capture it that cycle.
interface vedic_prod_accum_if #(
    parameter int ACC_W = 12
) ();
    logic             ena;
    logic [7:0]       prod_in;
    logic             prod_vld;
    logic             acc_clr;
    logic [ACC_W-1:0] sum_out;
    logic             sum_vld;
    logic             ovf;
    logic             busy;
    logic [7:0]       cnt_out;

    modport master (
        output ena, prod_in, prod_vld, acc_clr,
        input  sum_out, sum_vld, ovf, busy, cnt_out
    );

    modport slave (
        input  ena, prod_in, prod_vld, acc_clr,
        output sum_out, sum_vld, ovf, busy, cnt_out
    );
endinterface

// File: rtl/vedic_prod_accum.sv
// Accumulates BATCH multiplier products into a registered batch sum with overflow flag.
// Define VEDIC_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module vedic_prod_accum #(
    parameter int ACC_W = 12,
    parameter int BATCH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    vedic_prod_accum_if.slave  bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]       BATCH_CNT = 8'(BATCH);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;
    logic             sum_vld_q, sum_vld_d, busy_q;

    logic             accept;
    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] acc_next;
    logic [7:0]       cnt_next;
    logic             ovf_next;

    assign accept = bus.ena & bus.prod_vld & ~bus.acc_clr;

    // Value the batch would hold after taking prod_in; outside ACC a new batch starts.
    always_comb begin
        add_full = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.prod_in};
        if (state_q == ACC) begin
            cnt_next = cnt_q + 8'd1;
            ovf_next = ovf_acc_q | add_full[ACC_W];
`ifdef VEDIC_ACC_SATURATE_EN
            acc_next = add_full[ACC_W] ? ACC_MAX : add_full[ACC_W-1:0];
`else
            acc_next = add_full[ACC_W-1:0];
`endif
        end else begin
            cnt_next = 8'd1;
            ovf_next = 1'b0;
            acc_next = {{(ACC_W-8){1'b0}}, bus.prod_in};
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        sum_vld_d = 1'b0;
        if (bus.ena) begin
            if (bus.acc_clr) begin
                state_d   = IDLE;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_acc_d = 1'b0;
            end else if (accept) begin
                if (cnt_next == BATCH_CNT) begin
                    sum_d     = acc_next;
                    ovf_d     = ovf_next;
                    sum_vld_d = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    acc_d     = acc_next;
                    cnt_d     = cnt_next;
                    ovf_acc_d = ovf_next;
                    state_d   = ACC;
                end
            end else if (state_q == DONE) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            sum_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            sum_vld_q <= sum_vld_d;
            busy_q    <= (state_d == ACC);
        end
    end

    assign bus.sum_out = sum_q;
    assign bus.sum_vld = sum_vld_q;
    assign bus.ovf     = ovf_q;
    assign bus.busy    = busy_q;
    assign bus.cnt_out = cnt_q;
    assign dbg_state   = state_q;
endmodule
